cordic_arbiter: RTL and testbench

Shares one pipelined `cordic` rotator between `NCH` requesters, such as NCO or mixer channels, using a valid/ready request interface. The block:
- grants at most one request per cycle, round-robin;
- drives the rotator's clock-enable for backpressure;
- carries a channel tag alongside each operand through a matched-latency shift register, so every result returns labelled with its originating channel.

It sits between the channel front-ends and the single `cordic` instance in the SoC datapath.

---
 rtl/cordic_arbiter.sv | 108 ++++++++++
 tb/tb_cordic_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one pipelined cordic rotator among NCH valid/ready requesters, tagging results by channel.
// Build option: define CORDIC_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module cordic_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = 12,
  parameter int OW  = 12,
  parameter int PW  = 19,
  parameter int LAT = 17,
  parameter int TW  = $clog2(NCH)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NCH-1:0]    i_req_valid,
  output logic [NCH-1:0]    o_req_ready,
  input  logic [NCH*IW-1:0] i_req_xval,
  input  logic [NCH*IW-1:0] i_req_yval,
  input  logic [NCH*PW-1:0] i_req_phase,
  output logic              o_cordic_reset,
  output logic              o_cordic_ce,
  output logic [IW-1:0]     o_cordic_xval,
  output logic [IW-1:0]     o_cordic_yval,
  output logic [PW-1:0]     o_cordic_phase,
  output logic              o_cordic_aux,
  input  logic [OW-1:0]     i_cordic_xval,
  input  logic [OW-1:0]     i_cordic_yval,
  input  logic              i_cordic_aux,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [TW-1:0]     o_res_ch,
  output logic [OW-1:0]     o_res_xval,
  output logic [OW-1:0]     o_res_yval,
  output logic              o_busy,
  output logic              o_err
);
  logic [1:0]     r_sync;
  logic [LAT-1:0] r_pv;
  logic [TW-1:0]  r_pt [LAT];
  logic           r_err;
  logic           w_any;
  logic [TW-1:0]  w_gnt;
  logic [TW-1:0]  w_idx;
`ifndef CORDIC_ARB_FIXED_PRIO_EN
  logic [TW-1:0]  r_rr;
`endif

  // Rotator reset asserts immediately and releases two clocks after i_reset_n rises
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_sync <= '0;
    else r_sync <= {r_sync[0], 1'b1};

  assign o_cordic_reset = ~r_sync[1];
  assign o_cordic_ce    = ~o_cordic_reset & (~o_res_valid | i_res_ready);

  // Pick the first requesting channel; scanning downward lets the closest one win
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int i = NCH-1; i >= 0; i--) begin
`ifdef CORDIC_ARB_FIXED_PRIO_EN
      w_idx = TW'(i);
`else
      w_idx = TW'((int'(r_rr) + i) % NCH);
`endif
      if (i_req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
    w_any = w_any & ~o_cordic_reset;
  end

`ifndef CORDIC_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves just past the channel that transferred
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_rr <= '0;
    else if (w_any && o_cordic_ce) r_rr <= (w_gnt == TW'(NCH-1)) ? '0 : w_gnt + TW'(1);
`endif

  assign o_req_ready    = (w_any && o_cordic_ce) ? NCH'(1) << w_gnt : '0;
  assign o_cordic_aux   = w_any;
  assign o_cordic_xval  = w_any ? i_req_xval[w_gnt*IW +: IW] : '0;
  assign o_cordic_yval  = w_any ? i_req_yval[w_gnt*IW +: IW] : '0;
  assign o_cordic_phase = w_any ? i_req_phase[w_gnt*PW +: PW] : '0;

  // Tag pipe mirrors the rotator depth and advances only with its clock-enable
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_pv <= '0;
      for (int i = 0; i < LAT; i++) r_pt[i] <= '0;
    end else if (o_cordic_ce) begin
      r_pv    <= {r_pv[LAT-2:0], o_cordic_aux};
      r_pt[0] <= w_gnt;
      for (int i = 1; i < LAT; i++) r_pt[i] <= r_pt[i-1];
    end

  // Sticky flag when the tag pipe and rotator valid disagree
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_err <= 1'b0;
    else if (!o_cordic_reset && (r_pv[LAT-1] != i_cordic_aux)) r_err <= 1'b1;

  assign o_res_valid = i_cordic_aux;
  assign o_res_ch    = r_pt[LAT-1];
  assign o_res_xval  = i_cordic_xval;
  assign o_res_yval  = i_cordic_yval;
  assign o_busy      = |r_pv;
  assign o_err       = r_err;
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed checks of cordic_arbiter against a behavioural rotator stub.
module tb_cordic_arbiter;
  localparam int NCH = 4, IW = 12, OW = 12, PW = 19, LAT = 17, TW = 2;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    valid, ready;
  logic [NCH*IW-1:0] xv, yv;
  logic [NCH*PW-1:0] ph;
  logic              cr, ce, aux, res_valid, res_ready, busy, err;
  logic [IW-1:0]     cx, cy;
  logic [PW-1:0]     cp;
  logic [OW-1:0]     rx, ry, ox, oy;
  logic [TW-1:0]     res_ch;
  int n_assert = 0, n_fail = 0;
  int nb, nv;
  logic [OW-1:0] xexp [NCH];

  always #5 clk = ~clk;

  cordic_arbiter #(.NCH(NCH), .IW(IW), .OW(OW), .PW(PW), .LAT(LAT), .TW(TW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(valid), .o_req_ready(ready),
    .i_req_xval(xv), .i_req_yval(yv), .i_req_phase(ph),
    .o_cordic_reset(cr), .o_cordic_ce(ce), .o_cordic_xval(cx), .o_cordic_yval(cy),
    .o_cordic_phase(cp), .o_cordic_aux(aux), .i_cordic_xval(rx), .i_cordic_yval(ry),
    .i_cordic_aux(res_valid), .o_res_valid(), .i_res_ready(res_ready), .o_res_ch(res_ch),
    .o_res_xval(ox), .o_res_yval(oy), .o_busy(busy), .o_err(err)
  );

  // Rotator stub: LAT-deep enabled pipe, x scaled by the cordic gain (1192/1024), y passed through
  logic          m_v [LAT];
  logic [OW-1:0] m_x [LAT];
  logic [OW-1:0] m_y [LAT];
  always @(posedge clk)
    if (cr) begin
      for (int i = 0; i < LAT; i++) m_v[i] <= 1'b0;
    end else if (ce) begin
      m_v[0] <= aux;
      m_x[0] <= OW'((int'(cx) * 1192) >> 10);
      m_y[0] <= cy;
      for (int i = 1; i < LAT; i++) begin
        m_v[i] <= m_v[i-1];
        m_x[i] <= m_x[i-1];
        m_y[i] <= m_y[i-1];
      end
    end
  assign res_valid = m_v[LAT-1];
  assign rx = m_x[LAT-1];
  assign ry = m_y[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    #1 chk("reset_release", cr, 0);
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) begin
      m_v[i] = 1'b0; m_x[i] = '0; m_y[i] = '0;
    end
    xexp = '{12'h12A, 12'h254, 12'h37E, 12'h4A8};
    rst_n = 1'b0; valid = '0; res_ready = 1'b1; xv = '0; yv = '0; ph = '0;
    xv[2*IW +: IW] = 12'h400;
    repeat (2) @(posedge clk);
    #1 valid = 4'b0100;
    #1;
    chk("rst_cordic_reset", cr, 1);
    chk("rst_ce", ce, 0);
    chk("rst_ready", ready, 0);
    chk("rst_aux", aux, 0);
    chk("rst_xval", cx, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_ch", res_ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    #1 chk("rel0_reset", cr, 1);
    chk("rel0_ready", ready, 0);
    tick();
    #1 chk("rel1_reset", cr, 1);
    chk("rel1_ready", ready, 0);
    tick();
    #1 chk("rel2_reset", cr, 0);
    chk("single_ready", ready, 4'b0100);
    chk("single_aux", aux, 1);
    chk("single_xval", cx, 12'h400);
    chk("single_yval", cy, 0);
    chk("single_phase", cp, 0);
    chk("single_ce", ce, 1);
    tick();
    valid = '0;
    #1 chk("single_busy", busy, 1);
    chk("single_idle_ready", ready, 0);
    nb = 1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      #1 chk("single_wait", res_valid, 0);
      nb += int'(busy);
    end
    tick();
    #1 chk("single_valid", res_valid, 1);
    chk("single_ch", res_ch, 2);
    chk("single_x", ox, 12'h4A8);
    chk("single_y", oy, 0);
    nb += int'(busy);
    tick();
    #1 chk("single_done", res_valid, 0);
    chk("single_busy_off", busy, 0);
    chk("single_busy_cycles", nb, LAT);
    chk("single_err", err, 0);

    for (int k = 0; k < NCH; k++) begin
      xv[k*IW +: IW] = IW'((k + 1) * 'h100);
      yv[k*IW +: IW] = IW'(k * 'h10);
      ph[k*PW +: PW] = PW'(k * 'h1000);
    end
    do_reset();
    valid = 4'hF;
    for (int c = 0; c < 25; c++) begin
      if (c == 8) valid = '0;
      #1;
      if (c < 8) begin
        chk("rr_ready", ready, 32'd1 << (c % 4));
        chk("rr_xval", cx, (c % 4 + 1) * 'h100);
        chk("rr_phase", cp, (c % 4) * 'h1000);
      end else if (c < 17) chk("rr_gap", res_valid, 0);
      else begin
        chk("rr_valid", res_valid, 1);
        chk("rr_ch", res_ch, (c - 17) % 4);
        chk("rr_x", ox, xexp[(c - 17) % 4]);
        chk("rr_y", oy, ((c - 17) % 4) * 'h10);
      end
      tick();
    end
    #1 chk("rr_drain", res_valid, 0);
    chk("rr_busy", busy, 0);
    chk("rr_err", err, 0);

    for (int c = 0; c < 27; c++) begin
      valid = (c < 4) ? 4'hF : (c >= 17 && c <= 21) ? 4'b0010 : 4'h0;
      res_ready = !(c >= 17 && c <= 21);
      #1;
      if (c >= 17 && c <= 22) begin
        chk("bp_hold_valid", res_valid, 1);
        chk("bp_hold_ch", res_ch, 0);
        chk("bp_hold_x", ox, 12'h12A);
        chk("bp_hold_y", oy, 0);
      end
      if (c >= 17 && c <= 21) begin
        chk("bp_ce", ce, 0);
        chk("bp_ready", ready, 0);
      end
      if (c == 22) chk("bp_ce_back", ce, 1);
      if (c >= 23 && c <= 25) begin
        chk("bp_order_ch", res_ch, c - 22);
        chk("bp_order_x", ox, xexp[c - 22]);
      end
      if (c == 26) chk("bp_drain", res_valid, 0);
      tick();
    end
    chk("bp_err", err, 0);

    for (int c = 0; c < 8; c++) begin
      valid = (c < 6) ? 4'hF : 4'h0;
      tick();
    end
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1 chk("mid_busy", busy, 0);
    chk("mid_cordic_reset", cr, 1);
    chk("mid_ch", res_ch, 0);
    tick();
    tick();
    rst_n = 1'b1;
    nv = 0;
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      nv += int'(res_valid);
      nb += int'(busy);
    end
    chk("mid_no_results", nv, 0);
    chk("mid_no_busy", nb, 0);
    chk("mid_err", err, 0);

    valid = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      #1;
`ifdef CORDIC_ARB_FIXED_PRIO_EN
      chk("fp_ready", ready, 4'b0001);
`else
      chk("rr03_ready", ready, (c % 2 == 0) ? 4'b0001 : 4'b1000);
`endif
      tick();
    end
    valid = '0;
    repeat (LAT + 2) tick();
    chk("final_busy", busy, 0);
    chk("final_err", err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
